// File: rtl/mar_seq_pkg.sv
// rtl/mar_seq_pkg.sv - state encoding, MAR select codes and helpers for mar_seq_ctrl
// Optional PC-fetch states exist only when MAR_SEQ_PC_FETCH_EN is defined.
package mar_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FIN    = 3'd4
`ifdef MAR_SEQ_PC_FETCH_EN
        ,
        ST_FADDR  = 3'd5,
        ST_FACC   = 3'd6
`endif
    } state_t;

    // {MARMUX2, MARMUX1}: ALU wins over PC, zero means MAR+4
    typedef logic [1:0] mar_sel_t;
    localparam mar_sel_t SEL_INC = 2'b00;
    localparam mar_sel_t SEL_PC  = 2'b01;
    localparam mar_sel_t SEL_ALU = 2'b10;

    localparam int WAIT_MAX_DEF = 15;

    function automatic logic [4:0] popcount16(input logic [15:0] vec);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mar_seq_ctrl_if.sv
// rtl/mar_seq_ctrl_if.sv - control/memory handshake bundle between decode and the MAR sequencer
// FETCH is present only when MAR_SEQ_PC_FETCH_EN is defined.
interface mar_seq_ctrl_if;

    logic        START;
    logic [15:0] REG_LIST;
    logic        LOAD;
    logic        MEM_READY;
`ifdef MAR_SEQ_PC_FETCH_EN
    logic        FETCH;
`endif
    logic        LATCH_MAR;
    logic        MARMUX1;
    logic        MARMUX2;
    logic        MEM_EN;
    logic        MEM_RW;
    logic [3:0]  REG_SEL;
    logic        REG_WE;
    logic [4:0]  NUM_REGS;
    logic        BUSY;
    logic        DONE;
    logic        TIMEOUT;

    modport slave (
`ifdef MAR_SEQ_PC_FETCH_EN
        input  FETCH,
`endif
        input  START, REG_LIST, LOAD, MEM_READY,
        output LATCH_MAR, MARMUX1, MARMUX2, MEM_EN, MEM_RW,
        output REG_SEL, REG_WE, NUM_REGS, BUSY, DONE, TIMEOUT
    );

    modport master (
`ifdef MAR_SEQ_PC_FETCH_EN
        output FETCH,
`endif
        output START, REG_LIST, LOAD, MEM_READY,
        input  LATCH_MAR, MARMUX1, MARMUX2, MEM_EN, MEM_RW,
        input  REG_SEL, REG_WE, NUM_REGS, BUSY, DONE, TIMEOUT
    );

endinterface

// File: rtl/lsb_find16.sv
// rtl/lsb_find16.sv - lowest-set-bit priority encoder over 16 bits
// valid doubles as a non-empty flag for the scanned vector.
module lsb_find16 (
    input  logic [15:0] vec,
    output logic [3:0]  index,
    output logic        valid
);

    always_comb begin
        index = 4'd0;
        valid = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                index = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mar_seq_ctrl.sv
// rtl/mar_seq_ctrl.sv - LDM/STM block-transfer sequencer driving the MAR and memory handshake
// Optional PC fetch path enabled by MAR_SEQ_PC_FETCH_EN.
module mar_seq_ctrl
    import mar_seq_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic          CLK,
    input  logic          RESET,
    mar_seq_ctrl_if.slave bus
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    if (ADDR_W < 3 || WAIT_MAX < 1) begin : g_param_chk
        $error("mar_seq_ctrl: ADDR_W must be >= 3 and WAIT_MAX >= 1");
    end

    state_t       state, state_nx;
    mar_sel_t     mar_sel;
    logic [15:0]  pending;
    logic [15:0]  pend_clr;
    logic [15:0]  scan_vec;
    logic [3:0]   scan_idx;
    logic         scan_valid;
    logic         load_q;
    logic [CW-1:0] wait_cnt;
    logic         wait_at_max;

    logic latch_mar, mem_en, mem_rw, reg_we, done, timeout;
    logic [3:0] reg_sel;
    logic capture, clear_bit, clear_all, wait_inc, wait_clr;

    // One encoder serves both jobs: empty check of the incoming list in IDLE,
    // lowest pending register everywhere else.
    assign scan_vec    = (state == ST_IDLE) ? bus.REG_LIST : pending;
    assign pend_clr    = pending & ~(16'h0001 << scan_idx);
    assign wait_at_max = (wait_cnt == CW'(WAIT_MAX));

    lsb_find16 u_scan (
        .vec   (scan_vec),
        .index (scan_idx),
        .valid (scan_valid)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        mar_sel   = SEL_INC;
        latch_mar = 1'b0;
        mem_en    = 1'b0;
        mem_rw    = 1'b0;
        reg_sel   = 4'd0;
        reg_we    = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        capture   = 1'b0;
        clear_bit = 1'b0;
        clear_all = 1'b0;
        wait_inc  = 1'b0;
        wait_clr  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.START) begin
                    capture  = 1'b1;
                    state_nx = scan_valid ? ST_ADDR : ST_FIN;
                end
`ifdef MAR_SEQ_PC_FETCH_EN
                else if (bus.FETCH) begin
                    state_nx = ST_FADDR;
                end
`endif
            end
            ST_ADDR: begin
                latch_mar = 1'b1;
                mar_sel   = SEL_ALU;
                wait_clr  = 1'b1;
                state_nx  = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_en  = 1'b1;
                mem_rw  = load_q;
                reg_sel = scan_idx;
                if (bus.MEM_READY) begin
                    reg_we    = load_q;
                    clear_bit = 1'b1;
                    state_nx  = (|pend_clr) ? ST_NEXT : ST_FIN;
                end else if (wait_at_max) begin
                    timeout   = 1'b1;
                    clear_all = 1'b1;
                    state_nx  = ST_IDLE;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_NEXT: begin
                latch_mar = 1'b1;
                mar_sel   = SEL_INC;
                wait_clr  = 1'b1;
                state_nx  = ST_ACCESS;
            end
            ST_FIN: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
`ifdef MAR_SEQ_PC_FETCH_EN
            ST_FADDR: begin
                latch_mar = 1'b1;
                mar_sel   = SEL_PC;
                wait_clr  = 1'b1;
                state_nx  = ST_FACC;
            end
            ST_FACC: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
                if (bus.MEM_READY) begin
                    state_nx = ST_FIN;
                end else if (wait_at_max) begin
                    timeout  = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    wait_inc = 1'b1;
                end
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pending  <= '0;
            load_q   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (capture) begin
                pending <= bus.REG_LIST;
                load_q  <= bus.LOAD;
            end else if (clear_all) begin
                pending <= '0;
            end else if (clear_bit) begin
                pending <= pend_clr;
            end
            if (wait_clr) begin
                wait_cnt <= '0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

    assign bus.LATCH_MAR = latch_mar;
    assign bus.MARMUX2   = (mar_sel == SEL_ALU);
`ifdef MAR_SEQ_PC_FETCH_EN
    assign bus.MARMUX1   = (mar_sel == SEL_PC);
`else
    assign bus.MARMUX1   = 1'b0;
`endif
    assign bus.MEM_EN    = mem_en;
    assign bus.MEM_RW    = mem_rw;
    assign bus.REG_SEL   = reg_sel;
    assign bus.REG_WE    = reg_we;
    assign bus.NUM_REGS  = popcount16(bus.REG_LIST);
    assign bus.BUSY      = (state != ST_IDLE);
    assign bus.DONE      = done;
    assign bus.TIMEOUT   = timeout;

endmodule

// File: tb/tb_mar_seq_ctrl.sv
// tb/tb_mar_seq_ctrl.sv - randomized self-checking bench for mar_seq_ctrl
// Fetch scenarios compile in when MAR_SEQ_PC_FETCH_EN is defined.
module tb_mar_seq_ctrl;

    localparam int WAIT_MAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    mar_seq_ctrl_if bus ();

    mar_seq_ctrl #(.ADDR_W(32), .WAIT_MAX(WAIT_MAX)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    // Model: register order is the ascending set bits; access j begins at cycle
    // s_j (s_0 = 2) and lasts d_j+1 cycles, followed by one NEXT or FIN cycle.
    task automatic run_xfer(input string name, input logic [15:0] list, input logic ld,
                            input int dly[16], input bit noise);
        int regs[$];
        int n, s, to_k, exp_done, exp_to, exp_en, exp_lat, exp_acc;
        int k, w, en_cycles, latches, acc_cnt, cyc_err, done_c, to_c;
        logic hit;
        for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(i);
        n = regs.size();
        s = 2; to_k = -1; exp_done = -1; exp_to = -1; exp_en = 0;
        if (n == 0) exp_done = 1;
        for (int j = 0; j < n; j++) begin
            if (dly[j] > WAIT_MAX) begin
                exp_to = s + WAIT_MAX; exp_en += WAIT_MAX + 1; to_k = j;
                break;
            end
            exp_en += dly[j] + 1;
            if (j == n - 1) exp_done = s + dly[j] + 1;
            s += dly[j] + 2;
        end
        exp_lat = (n == 0) ? 0 : ((to_k >= 0) ? to_k + 1 : n);
        exp_acc = (to_k >= 0) ? to_k : n;

        @(negedge clk);
        bus.START = 1'b1; bus.REG_LIST = list; bus.LOAD = ld; bus.MEM_READY = 1'b0;
        #1;
        vectors++;
        if (bus.NUM_REGS !== 5'($countones(list))) begin
            errors++;
            $display("FAIL %s num_regs: got %0d want %0d", name, bus.NUM_REGS, $countones(list));
        end
        k = 0; w = 0; en_cycles = 0; latches = 0; acc_cnt = 0; cyc_err = 0; done_c = -1; to_c = -1;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            if (bus.MEM_EN) bus.MEM_READY = (k < n && k < 16 && w == dly[k]);
            else bus.MEM_READY = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            hit = bus.MEM_EN && bus.MEM_READY;
            if (bus.MEM_EN) begin
                en_cycles++;
                if (k >= n || bus.REG_SEL !== 4'(regs[k]) || bus.MEM_RW !== ld) cyc_err++;
            end
            if (bus.REG_WE !== (hit && ld)) cyc_err++;
            if (bus.BUSY !== 1'b1) cyc_err++;
            if (bus.MARMUX2 !== (c == 1 && n != 0)) cyc_err++;
            if (bus.MARMUX2 && !bus.LATCH_MAR) cyc_err++;
            if (bus.MARMUX1 !== 1'b0) cyc_err++;
            if (bus.LATCH_MAR) latches++;
            if (hit) begin acc_cnt++; k++; w = 0; end
            else if (bus.MEM_EN) w++;
            if (bus.DONE) done_c = c;
            if (bus.TIMEOUT) to_c = c;
            if (bus.DONE || bus.TIMEOUT || !noise) bus.START = 1'b0;
            else begin
                bus.START = 1'($urandom_range(0, 1));
                bus.REG_LIST = 16'($urandom);
                bus.LOAD = 1'($urandom_range(0, 1));
            end
            if (bus.DONE || bus.TIMEOUT) break;
        end
        bus.START = 1'b0;

        vectors++;
        if (done_c !== exp_done) begin
            errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_c, exp_done);
        end
        vectors++;
        if (to_c !== exp_to) begin
            errors++; $display("FAIL %s timeout_cycle: got %0d want %0d", name, to_c, exp_to);
        end
        vectors++;
        if (en_cycles !== exp_en || acc_cnt !== exp_acc) begin
            errors++;
            $display("FAIL %s mem_en_cycles/accesses: got %0d/%0d want %0d/%0d",
                     name, en_cycles, acc_cnt, exp_en, exp_acc);
        end
        vectors++;
        if (latches !== exp_lat) begin
            errors++; $display("FAIL %s latch_mar_count: got %0d want %0d", name, latches, exp_lat);
        end
        vectors++;
        if (cyc_err !== 0) begin
            errors++; $display("FAIL %s per_cycle_outputs: got %0d bad cycles want 0", name, cyc_err);
        end
        @(negedge clk);
        bus.MEM_READY = 1'b0;
        #1;
        vectors++;
        if ({bus.BUSY, bus.DONE, bus.TIMEOUT, bus.MEM_EN} !== 4'b0000) begin
            errors++;
            $display("FAIL %s idle_after: got busy/done/to/en=%b want 0000", name,
                     {bus.BUSY, bus.DONE, bus.TIMEOUT, bus.MEM_EN});
        end
    endtask

    task automatic test_reset();
        logic [15:0] outs;
        bus.START = 1'b0; bus.REG_LIST = 16'hA5A5; bus.LOAD = 1'b0; bus.MEM_READY = 1'b0;
`ifdef MAR_SEQ_PC_FETCH_EN
        bus.FETCH = 1'b0;
`endif
        rst = 1'b1;
        #1;
        outs = {bus.LATCH_MAR, bus.MARMUX1, bus.MARMUX2, bus.MEM_EN, bus.MEM_RW,
                bus.REG_SEL, bus.REG_WE, bus.BUSY, bus.DONE, bus.TIMEOUT, 3'b000};
        vectors++;
        if (outs !== 16'h0000) begin
            errors++; $display("FAIL reset_outputs: got %h want 0000", outs);
        end
        vectors++;
        if (bus.NUM_REGS !== 5'd8) begin
            errors++; $display("FAIL reset_num_regs: got %0d want 8", bus.NUM_REGS);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int z[16];
        @(negedge clk);
        bus.START = 1'b1; bus.REG_LIST = 16'h00F0; bus.LOAD = 1'b1; bus.MEM_READY = 1'b0;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (bus.MEM_EN !== 1'b1 || bus.REG_SEL !== 4'd4) begin
            errors++; $display("FAIL rst_mid pre_access: got en=%b sel=%0d want en=1 sel=4",
                               bus.MEM_EN, bus.REG_SEL);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.MEM_EN, bus.LATCH_MAR, bus.BUSY, bus.REG_WE} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid async_drop: got en/latch/busy/we=%b want 0000",
                               {bus.MEM_EN, bus.LATCH_MAR, bus.BUSY, bus.REG_WE});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (bus.BUSY !== 1'b0) begin
            errors++; $display("FAIL rst_mid idle_after: got busy=%b want 0", bus.BUSY);
        end
        for (int i = 0; i < 16; i++) z[i] = 0;
        run_xfer("rst_mid_restart", 16'h00F0, 1'b1, z, 1'b0);
    endtask

    task automatic test_directed();
        int d[16];
        for (int i = 0; i < 16; i++) d[i] = 0;
        run_xfer("ldm_8005", 16'h8005, 1'b1, d, 1'b0);
        d[0] = 4;
        run_xfer("stm_0001_wait4", 16'h0001, 1'b0, d, 1'b0);
        d[0] = 0;
        run_xfer("empty_list", 16'h0000, 1'b1, d, 1'b0);
        d[0] = WAIT_MAX;
        run_xfer("wait_boundary", 16'h0003, 1'b1, d, 1'b0);
        d[0] = 1000;
        run_xfer("timeout_busy_start", 16'h0010, 1'b0, d, 1'b1);
    endtask

    task automatic test_random();
        int d[16];
        int r;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 16; i++) begin
                r = $urandom_range(0, 39);
                d[i] = (r == 0) ? 1000 : (r == 1) ? WAIT_MAX : $urandom_range(0, 3);
            end
            run_xfer($sformatf("rand_%0d", t), 16'($urandom) & 16'($urandom),
                     1'($urandom_range(0, 1)), d, 1'b1);
        end
    endtask

`ifdef MAR_SEQ_PC_FETCH_EN
    task automatic test_fetch();
        @(negedge clk);
        bus.FETCH = 1'b1; bus.START = 1'b0; bus.MEM_READY = 1'b0;
        @(negedge clk);
        bus.FETCH = 1'b0;
        #1;
        vectors++;
        if ({bus.LATCH_MAR, bus.MARMUX1, bus.MARMUX2} !== 3'b110) begin
            errors++; $display("FAIL fetch_addr: got latch/mux1/mux2=%b want 110",
                               {bus.LATCH_MAR, bus.MARMUX1, bus.MARMUX2});
        end
        @(negedge clk);
        bus.MEM_READY = 1'b1;
        #1;
        vectors++;
        if ({bus.MEM_EN, bus.MEM_RW, bus.REG_SEL, bus.REG_WE} !== 7'b1100000) begin
            errors++; $display("FAIL fetch_access: got %b want 1100000",
                               {bus.MEM_EN, bus.MEM_RW, bus.REG_SEL, bus.REG_WE});
        end
        @(negedge clk);
        bus.MEM_READY = 1'b0;
        #1;
        vectors++;
        if (bus.DONE !== 1'b1) begin
            errors++; $display("FAIL fetch_done: got %b want 1", bus.DONE);
        end
        @(negedge clk);
        bus.START = 1'b1; bus.FETCH = 1'b1; bus.REG_LIST = 16'h0002; bus.LOAD = 1'b1;
        @(negedge clk);
        bus.START = 1'b0; bus.FETCH = 1'b0;
        #1;
        vectors++;
        if ({bus.MARMUX1, bus.MARMUX2} !== 2'b01) begin
            errors++; $display("FAIL fetch_start_priority: got mux1/mux2=%b want 01",
                               {bus.MARMUX1, bus.MARMUX2});
        end
        @(negedge clk);
        bus.MEM_READY = 1'b1;
        #1;
        vectors++;
        if ({bus.REG_SEL, bus.REG_WE} !== 5'b00011) begin
            errors++; $display("FAIL fetch_start_access: got sel/we=%b want 00011",
                               {bus.REG_SEL, bus.REG_WE});
        end
        @(negedge clk);
        bus.MEM_READY = 1'b0;
        #1;
        vectors++;
        if (bus.DONE !== 1'b1) begin
            errors++; $display("FAIL fetch_start_done: got %b want 1", bus.DONE);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_access();
        test_directed();
        test_random();
`ifdef MAR_SEQ_PC_FETCH_EN
        test_fetch();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
